// File: rtl/clk_rst_gen.sv
// clk_rst_gen: PLL lock qualifier, system reset and per-channel clock-enable generator.
// Define CLK_RST_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module clk_rst_gen #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int NUM_CE         = 2,
    parameter int CE_DIV_WIDTH   = 16,
    parameter int LOSS_CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_,
    input  logic                           pll_locked,
    input  logic [NUM_CE*CE_DIV_WIDTH-1:0] ce_div,
    output logic                           sys_reset_,
    output logic                           ready,
    output logic [NUM_CE-1:0]              ce,
`ifdef CLK_RST_LOSS_CNT_EN
    output logic [LOSS_CNT_WIDTH-1:0]      lock_loss_cnt,
`endif
    output logic [1:0]                     state
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1 ||
        NUM_CE < 1 || CE_DIV_WIDTH < 1 || LOSS_CNT_WIDTH < 1) begin : g_bad_param
        $error("clk_rst_gen: illegal parameter value");
    end

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    logic [SW-1:0]          r_stable_cnt;
    logic [SW-1:0]          w_stable_nxt;
    logic [HW-1:0]          r_hold_cnt;
    logic [HW-1:0]          w_hold_nxt;
    logic                   r_sys_rst;
    logic                   r_ready;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state      <= WAIT_LOCK;
            r_stable_cnt <= '0;
            r_hold_cnt   <= '0;
            r_sys_rst    <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_stable_cnt <= w_stable_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_sys_rst    <= (w_next == RUN);
            r_ready      <= (w_next == RUN);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_stable_nxt = r_stable_cnt;
        w_hold_nxt   = r_hold_cnt;
        unique case (r_state)
            WAIT_LOCK: begin
                w_stable_nxt = '0;
                w_hold_nxt   = '0;
                if (w_lock_s) begin
                    w_next       = STABILIZE;
                    w_stable_nxt = SW'(1);
                end
            end
            STABILIZE: begin
                w_hold_nxt = '0;
                // any dropout restarts qualification from scratch
                if (!w_lock_s) begin
                    w_next       = WAIT_LOCK;
                    w_stable_nxt = '0;
                end else if (r_stable_cnt == STABLE_MAX) begin
                    w_next       = RUN;
                    w_stable_nxt = '0;
                end else begin
                    w_stable_nxt = r_stable_cnt + SW'(1);
                end
            end
            RUN: begin
                w_stable_nxt = '0;
                w_hold_nxt   = '0;
                if (!w_lock_s) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                w_stable_nxt = '0;
                if (r_hold_cnt == HOLD_LAST) begin
                    w_next     = WAIT_LOCK;
                    w_hold_nxt = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + HW'(1);
                end
            end
            default: begin
                w_next = WAIT_LOCK;
            end
        endcase
    end

    for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
        logic [CE_DIV_WIDTH-1:0] w_div;
        logic [CE_DIV_WIDTH-1:0] w_last;
        logic                    w_hit;
        logic [CE_DIV_WIDTH-1:0] r_div_cnt;
        logic                    r_ce;

        assign w_div  = ce_div[i*CE_DIV_WIDTH +: CE_DIV_WIDTH];
        // divisor 0 behaves as 1; >= lets a lowered divisor pulse at once
        assign w_last = (w_div == '0) ? '0 : w_div - CE_DIV_WIDTH'(1);
        assign w_hit  = (r_div_cnt >= w_last);

        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
                r_div_cnt <= '0;
                r_ce      <= 1'b0;
            end else if (w_next != RUN) begin
                r_div_cnt <= '0;
                r_ce      <= 1'b0;
            end else if (w_hit) begin
                r_div_cnt <= '0;
                r_ce      <= 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + CE_DIV_WIDTH'(1);
                r_ce      <= 1'b0;
            end
        end

        assign ce[i] = r_ce;
    end

`ifdef CLK_RST_LOSS_CNT_EN
    logic [LOSS_CNT_WIDTH-1:0] r_loss_cnt;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_loss_cnt <= '0;
        end else if (r_state == RUN && w_next == HOLD && r_loss_cnt != '1) begin
            r_loss_cnt <= r_loss_cnt + LOSS_CNT_WIDTH'(1);
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`endif

    assign sys_reset_ = r_sys_rst;
    assign ready      = r_ready;
    assign state      = r_state;

endmodule

// File: tb/tb_clk_rst_gen.sv
// tb_clk_rst_gen: directed tables plus randomized lock/divisor stimulus against
// a cycle-level reference model; a second small-parameter instance covers saturation.
module tb_clk_rst_gen;

    localparam int W   = 16;
    localparam int NCE = 2;
    localparam int SS  = 2;
    localparam int SC  = 1024;
    localparam int HC  = 16;

    logic             clk = 1'b0;
    logic             reset_;
    logic             pll_locked;
    logic [NCE*W-1:0] ce_div;
    logic             sys_reset_;
    logic             ready;
    logic [NCE-1:0]   ce;
    logic [1:0]       state;
`ifdef CLK_RST_LOSS_CNT_EN
    logic [7:0]       lock_loss_cnt;
    logic [7:0]       b_loss;
`endif

    logic       b_reset_;
    logic       b_lock;
    logic [3:0] b_div;
    logic       b_sys;
    logic       b_ready;
    logic [0:0] b_ce;
    logic [1:0] b_state;

    always #5 clk = ~clk;

    clk_rst_gen dut (
        .clk        (clk),
        .reset_     (reset_),
        .pll_locked (pll_locked),
        .ce_div     (ce_div),
        .sys_reset_ (sys_reset_),
        .ready      (ready),
        .ce         (ce),
`ifdef CLK_RST_LOSS_CNT_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .state      (state)
    );

    clk_rst_gen #(
        .SYNC_STAGES(3), .STABLE_CYCLES(4), .HOLD_CYCLES(2),
        .NUM_CE(1), .CE_DIV_WIDTH(4), .LOSS_CNT_WIDTH(8)
    ) dut_s (
        .clk        (clk),
        .reset_     (b_reset_),
        .pll_locked (b_lock),
        .ce_div     (b_div),
        .sys_reset_ (b_sys),
        .ready      (b_ready),
        .ce         (b_ce),
`ifdef CLK_RST_LOSS_CNT_EN
        .lock_loss_cnt (b_loss),
`endif
        .state      (b_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: lock history queue, qualification streak, hold countdown
    bit           mq[$];
    int           streak;
    int           hold_left;
    bit           run;
    int           since[NCE];
    bit [NCE-1:0] m_ce;
    int           m_loss;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < SS; i++) mq.push_back(1'b0);
        streak = 0;
        hold_left = 0;
        run = 1'b0;
        m_ce = '0;
        m_loss = 0;
        for (int i = 0; i < NCE; i++) since[i] = 0;
    endfunction

    function automatic int m_state();
        if (hold_left > 0) return 3;
        if (run) return 2;
        if (streak > 0) return 1;
        return 0;
    endfunction

    function automatic void model_edge();
        bit ls;
        int d;
        ls = mq.pop_front();
        mq.push_back(pll_locked);
        if (hold_left > 0) begin
            hold_left--;
        end else if (run) begin
            if (!ls) begin
                run = 1'b0;
                hold_left = HC;
                if (m_loss < 255) m_loss++;
            end
        end else begin
            streak = ls ? streak + 1 : 0;
            if (streak == SC + 1) begin
                run = 1'b1;
                streak = 0;
            end
        end
        for (int i = 0; i < NCE; i++) begin
            d = int'(ce_div[i*W +: W]);
            if (d == 0) d = 1;
            if (run) begin
                since[i]++;
                m_ce[i] = (since[i] >= d);
                if (m_ce[i]) since[i] = 0;
            end else begin
                since[i] = 0;
                m_ce[i] = 1'b0;
            end
        end
    endfunction

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state()));
        check("sys_reset_", 32'(sys_reset_), 32'(run));
        check("ready", 32'(ready), 32'(run));
        check("ce", 32'(ce), 32'(m_ce));
`ifdef CLK_RST_LOSS_CNT_EN
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2 reset_ = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_ce_async", 32'(ce), 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    task automatic wait_ready(input int max, output int n, output int last_wait);
        n = 0;
        last_wait = -1;
        while (!ready && n < max) begin
            step();
            n++;
            if (state == 2'd0) last_wait = n;
        end
    endtask

    typedef struct {
        int div0;
        int div1;
        int cycles;
        int rel;
        int p0;
        int p1;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int n, lw, h, s, c0, c1, t, b_to;

        tbl[0] = '{3, 0, 30, 1027, 10, 30};
        tbl[1] = '{1, 5, 20, 1027, 20, 4};
        tbl[2] = '{7, 2, 21, 1027, 3, 10};
        tbl[3] = '{16, 4, 48, 1027, 3, 12};

        reset_ = 1'b0;
        pll_locked = 1'b0;
        ce_div = {16'd0, 16'd3};
        b_reset_ = 1'b0;
        b_lock = 1'b0;
        b_div = 4'd2;
        #3;
        model_reset();
        compare_all();
        @(negedge clk);
        reset_ = 1'b1;
        b_reset_ = 1'b1;
        repeat (4) step();

        // release comes 1026 edges after the first edge sampling lock high
        pll_locked = 1'b1;
        wait_ready(2000, n, lw);
        check("release_latency", 32'(n), 32'd1027);
        check("stabilize_entry", 32'(lw), 32'd2);

        do_reset();
        pll_locked = 1'b1;
        repeat (502) step();
        check("pre_glitch_state", 32'(state), 32'd1);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_ready(2000, n, lw);
        check("glitch_release", 32'(n), 32'd1027);
        check("glitch_wait_lock", 32'(lw), 32'd2);

        repeat (3) step();
        pll_locked = 1'b0;
        n = 0;
        while (sys_reset_ && n < 10) begin
            step();
            n++;
            if (n == 3) pll_locked = 1'b1;
        end
        check("loss_latency", 32'(n), 32'd3);
        h = 0;
        while (state == 2'd3 && h < 100) begin
            h++;
            step();
        end
        check("hold_len", 32'(h), 32'd16);
        check("post_hold_state", 32'(state), 32'd0);
        s = 0;
        t = 0;
        while (!ready && t < 2000) begin
            step();
            t++;
            if (state == 2'd1) s++;
        end
        check("requal_len", 32'(s), 32'd1024);
`ifdef CLK_RST_LOSS_CNT_EN
        check("loss_cnt_one", 32'(lock_loss_cnt), 32'd1);
`endif

        for (int k = 0; k < 4; k++) begin
            do_reset();
            ce_div = {16'(tbl[k].div1), 16'(tbl[k].div0)};
            pll_locked = 1'b1;
            wait_ready(2000, n, lw);
            check("tbl_release", 32'(n), 32'(tbl[k].rel));
            c0 = int'(ce[0]);
            c1 = int'(ce[1]);
            repeat (tbl[k].cycles - 1) begin
                step();
                c0 += int'(ce[0]);
                c1 += int'(ce[1]);
            end
            check("tbl_pulses0", 32'(c0), 32'(tbl[k].p0));
            check("tbl_pulses1", 32'(c1), 32'(tbl[k].p1));
        end

        do_reset();
        ce_div = {16'd1, 16'd10};
        pll_locked = 1'b1;
        wait_ready(2000, n, lw);
        repeat (6) step();
        ce_div = {16'd1, 16'd2};
        step();
        check("div_drop_pulse", 32'(ce[0]), 32'd1);
        step();
        check("div_drop_gap", 32'(ce[0]), 32'd0);
        step();
        check("div_drop_next", 32'(ce[0]), 32'd1);

        // asynchronous reset while running with ce[1] active
        step();
        do_reset();
        check("midrun_sys", 32'(sys_reset_), 32'd0);
        check("midrun_state", 32'(state), 32'd0);

        b_reset_ = 1'b0;
        #1;
        check("b_rst_state", 32'(b_state), 32'd0);
        b_reset_ = 1'b1;
        b_lock = 1'b1;
        n = 0;
        while (!b_ready && n < 50) begin
            step();
            n++;
        end
        check("b_release", 32'(n), 32'd8);
        check("b_ce_first", 32'(b_ce), 32'd0);
        step();
        check("b_ce_second", 32'(b_ce), 32'd1);
        b_to = 0;
        for (int k = 0; k < 256; k++) begin
            b_lock = 1'b0;
            t = 0;
            while (b_sys && t < 20) begin
                step();
                t++;
            end
            h = 0;
            while (b_state == 2'd3 && h < 20) begin
                step();
                h++;
            end
            if (k == 0) begin
                check("b_fall", 32'(t), 32'd4);
                check("b_hold", 32'(h), 32'd2);
`ifdef CLK_RST_LOSS_CNT_EN
                check("b_loss_one", 32'(b_loss), 32'd1);
`endif
            end
            b_lock = 1'b1;
            t = 0;
            while (!b_ready && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) b_to++;
        end
        check("b_timeouts", 32'(b_to), 32'd0);
`ifdef CLK_RST_LOSS_CNT_EN
        check("b_loss_sat", 32'(b_loss), 32'd255);
`endif

        do_reset();
        for (int seg = 0; seg < 24; seg++) begin
            if (seg == 13) do_reset();
            pll_locked = (seg % 2 == 0);
            if (pll_locked)
                n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40)
                                                : $urandom_range(1030, 1600);
            else
                n = $urandom_range(1, 30);
            repeat (n) begin
                if ($urandom_range(0, 31) == 0)
                    ce_div = {16'($urandom_range(0, 6)), 16'($urandom_range(0, 6))};
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
